// File: rtl/repeated_sub_divider_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package repeated_sub_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    LOAD_A = 3'b001,
    LOAD_B = 3'b010,
    ITER   = 3'b011,
    DONE   = 3'b100
  } state_e;

endpackage

// File: rtl/repeated_sub_divider_if.sv
// Operand/result bus between the sequencing logic (master) and the divider (slave).
interface repeated_sub_divider_if
  import repeated_sub_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, data_in,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, busy, done, div_zero
  );
endinterface

// File: rtl/repeated_sub_divider_dp.sv
// Divider datapath: remainder/divisor/quotient registers, subtractor, incrementer, status flags.
module repeated_sub_divider_dp #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             clr_q,
  input  logic             step,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ge,
  output logic             bz
);
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;

  always_comb begin
    rem_d = rem_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    if (ld_a)      rem_d = data_in;
    else if (step) rem_d = rem_q - dvs_q;
    if (ld_b)      dvs_d = data_in;
    if (clr_q)     quo_d = '0;
    else if (step) quo_d = quo_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
    end else begin
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
    end
  end

  assign ge        = (rem_q >= dvs_q);
  assign bz        = (dvs_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/repeated_sub_divider.sv
// Unsigned repeated-subtraction divider: controller FSM driving the datapath sub-module.
module repeated_sub_divider
  import repeated_sub_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  repeated_sub_divider_if.slave bus
);
  state_e state_q, state_d;
  logic   dz_q, dz_d;
  logic   ld_a, ld_b, clr_q, step;
  logic   ge, bz;

  always_comb begin
    state_d = state_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE:   if (bus.start) state_d = LOAD_A;
      LOAD_A: state_d = LOAD_B;
      LOAD_B: begin
        state_d = ITER;
        dz_d    = 1'b0;
      end
      ITER: begin
        if (bz) begin
          state_d = DONE;
          dz_d    = 1'b1;
        end else if (!ge) begin
          state_d = DONE;
        end
      end
      DONE:   if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dz_q    <= dz_d;
    end
  end

  // Zero divisor takes priority over the compare, so a step never fires when bz is set.
  assign ld_a  = (state_q == LOAD_A);
  assign ld_b  = (state_q == LOAD_B);
  assign clr_q = (state_q == LOAD_B);
  assign step  = (state_q == ITER) && !bz && ge;

  repeated_sub_divider_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .ld_a      (ld_a),
    .ld_b      (ld_b),
    .clr_q     (clr_q),
    .step      (step),
    .data_in   (bus.data_in),
    .quotient  (bus.quotient),
    .remainder (bus.remainder),
    .ge        (ge),
    .bz        (bz)
  );

  assign bus.busy     = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == ITER);
  assign bus.done     = (state_q == DONE);
  assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_repeated_sub_divider.sv
// Directed bench for repeated_sub_divider at WIDTH=16 and WIDTH=8.
module tb_repeated_sub_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  repeated_sub_divider_if #(.WIDTH(16)) b16 ();
  repeated_sub_divider_if #(.WIDTH(8))  b8  ();

  repeated_sub_divider #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  repeated_sub_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one division on the 16-bit instance starting from IDLE; cycle 0 is the start sample.
  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_q, input logic [15:0] exp_r, input logic exp_dz,
                       input int unsigned exp_cyc, input bit hold, input bit pulse);
    int unsigned cyc;
    logic [15:0] q_seen, r_seen;
    b16.start = 1'b1;
    tick();
    b16.start   = hold;
    b16.data_in = a;
    check({tag, "_busy_ld"}, 32'(b16.busy), 32'd1);
    tick();
    b16.data_in = b;
    tick();
    b16.data_in = 16'hBEEF;
    cyc = 3;
    while (!b16.done && cyc < 2000) begin
      b16.start = hold || (pulse && cyc == 5);
      tick();
      cyc++;
    end
    b16.start = hold;
    check({tag, "_done_cyc"}, cyc, exp_cyc);
    check({tag, "_q"}, 32'(b16.quotient), 32'(exp_q));
    check({tag, "_r"}, 32'(b16.remainder), 32'(exp_r));
    check({tag, "_dz"}, 32'(b16.div_zero), 32'(exp_dz));
    check({tag, "_busy_done"}, 32'(b16.busy), 32'd0);
    q_seen = b16.quotient;
    r_seen = b16.remainder;
    if (hold) begin
      for (int unsigned i = 0; i < 3; i++) begin
        tick();
        check({tag, "_hold_done"}, 32'(b16.done), 32'd1);
        check({tag, "_hold_q"}, 32'(b16.quotient), 32'(exp_q));
        check({tag, "_hold_r"}, 32'(b16.remainder), 32'(exp_r));
      end
      b16.start = 1'b0;
      tick();
    end
    tick();
    check({tag, "_idle_done"}, 32'(b16.done), 32'd0);
    check({tag, "_idle_busy"}, 32'(b16.busy), 32'd0);
    check({tag, "_keep_q"}, 32'(b16.quotient), 32'(q_seen));
    check({tag, "_keep_r"}, 32'(b16.remainder), 32'(r_seen));
  endtask

  initial begin
    int unsigned cyc;
    b16.start = 1'b0; b16.data_in = '0;
    b8.start  = 1'b0; b8.data_in  = '0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_q", 32'(b16.quotient), 32'd0);
    check("rst_r", 32'(b16.remainder), 32'd0);
    check("rst_busy", 32'(b16.busy), 32'd0);
    check("rst_done", 32'(b16.done), 32'd0);
    check("rst_dz", 32'(b16.div_zero), 32'd0);
    check("rst8_busy", 32'(b8.busy), 32'd0);
    rst = 1'b0;
    tick();

    run16("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 18, 1'b0, 1'b0);
    run16("d5_9",   16'd5,   16'd9, 16'd0,  16'd5, 1'b0, 4,  1'b0, 1'b0);
    run16("d0_3",   16'd0,   16'd3, 16'd0,  16'd0, 1'b0, 4,  1'b0, 1'b0);
    run16("d42_0",  16'd42,  16'd0, 16'd0,  16'd42, 1'b1, 4, 1'b0, 1'b0);
    run16("d9_9",   16'd9,   16'd9, 16'd1,  16'd0, 1'b0, 5,  1'b0, 1'b0);
    run16("hold",   16'd17,  16'd5, 16'd3,  16'd2, 1'b0, 7,  1'b1, 1'b0);
    run16("pulse",  16'd50,  16'd8, 16'd6,  16'd2, 1'b0, 10, 1'b0, 1'b1);

    // Reset lands mid-ITER of 1000 / 3.
    b16.start = 1'b1;
    tick();
    b16.start = 1'b0; b16.data_in = 16'd1000;
    tick();
    b16.data_in = 16'd3;
    tick();
    repeat (4) tick();
    check("iter_busy", 32'(b16.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_q", 32'(b16.quotient), 32'd0);
    check("mid_rst_r", 32'(b16.remainder), 32'd0);
    check("mid_rst_busy", 32'(b16.busy), 32'd0);
    check("mid_rst_done", 32'(b16.done), 32'd0);
    check("mid_rst_dz", 32'(b16.div_zero), 32'd0);
    run16("d20_6", 16'd20, 16'd6, 16'd3, 16'd2, 1'b0, 7, 1'b0, 1'b0);

    // Worst case on the 8-bit instance: 255 / 1.
    b8.start = 1'b1;
    tick();
    b8.start = 1'b0; b8.data_in = 8'd255;
    tick();
    b8.data_in = 8'd1;
    tick();
    b8.data_in = 8'h5A;
    cyc = 3;
    while (!b8.done && cyc < 400) begin
      tick();
      cyc++;
    end
    check("w8_done_cyc", cyc, 32'd259);
    check("w8_q", 32'(b8.quotient), 32'd255);
    check("w8_r", 32'(b8.remainder), 32'd0);
    check("w8_dz", 32'(b8.div_zero), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/repeated_sub_divider.md
# repeated_sub_divider

Unsigned repeated-subtraction divider: the inverse partner of the team's repeated-addition multiplier. It loads a dividend and then a divisor over one shared `data_in` bus in consecutive cycles. It then subtracts the divisor from a running remainder once per cycle, counting the subtractions, until the remainder is less than the divisor. It is split into a controller FSM and a datapath, and it reports the quotient, remainder, done and divide-by-zero status to the surrounding sequencing logic.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level request; sampled only in IDLE and DONE.
- `data_in`  in  WIDTH  carries the dividend during LOAD_A and the divisor during LOAD_B.
- `quotient`  out  WIDTH  quotient register; valid while `done`=1.
- `remainder`  out  WIDTH  remainder register; valid while `done`=1.
- `busy`  out  1  high in LOAD_A, LOAD_B and ITER.
- `done`  out  1  high in DONE only.
- `div_zero`  out  1  high in DONE when the divisor was 0.

## Operation
- States: IDLE, LOAD_A, LOAD_B, ITER, DONE.
- IDLE: stays in IDLE while `start`=0. On `start`=1, goes to LOAD_A.
- LOAD_A:
  - `remainder` <= `data_in` (the dividend).
  - Always goes to LOAD_B.
- LOAD_B:
  - The divisor register <= `data_in`.
  - `quotient` <= 0 and `div_zero` <= 0.
  - Always goes to ITER.
- ITER, priority order, evaluated every cycle:
  1. Divisor == 0: `div_zero` <= 1, go to DONE. `quotient` and `remainder` are left unchanged, so `remainder` = dividend and `quotient` = 0.
  2. `remainder` >= divisor: `remainder` <= `remainder` − divisor, `quotient` <= `quotient` + 1, stay in ITER.
  3. Otherwise: go to DONE.
- DONE:
  - `done`=1; outputs are held stable.
  - Stays in DONE while `start`=1. Goes to IDLE when `start`=0.
  - A new operation therefore requires `start` to drop and rise again.
- Results stay valid in IDLE until the next LOAD_A/LOAD_B overwrites them.
- Arithmetic rules:
  - Unsigned, WIDTH bits throughout.
  - The compare is unsigned >=.
  - The subtraction cannot underflow because it only occurs when `remainder` >= divisor.
  - `quotient` cannot overflow: it is at most the dividend, which is at most 2^WIDTH − 1.
- `start` is ignored in LOAD_A, LOAD_B and ITER. `data_in` is ignored outside LOAD_A and LOAD_B.

## Timing
- Reset values: state IDLE; `quotient`, `remainder` and the divisor register all 0; `busy`, `done` and `div_zero` all 0.
- Reset applies on any edge where `rst`=1, including mid-ITER. `rst` overrides `start`.
- Cycle numbering: cycle 0 is IDLE with `start`=1.
  - Cycle 1 is LOAD_A; the dividend must be on `data_in`.
  - Cycle 2 is LOAD_B; the divisor must be on `data_in`.
  - ITER occupies cycles 3 through 3+Q, where Q is the final quotient.
  - `done` first rises in cycle 4+Q.
- Divide-by-zero: `done` and `div_zero` rise in cycle 4.
- Worst case: dividend 2^WIDTH − 1 with divisor 1 gives 2^WIDTH + 3 cycles from the `start` sample to `done`.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- Shared package `repeated_sub_divider_pkg` holds:
  - the state enum: IDLE=3'b000, LOAD_A=3'b001, LOAD_B=3'b010, ITER=3'b011, DONE=3'b100;
  - the default WIDTH constant.
- Top level `repeated_sub_divider` contains the controller FSM, which drives `ld_a`, `ld_b`, `clr_q` and `step` to the datapath.
- Sub-module `repeated_sub_divider_dp` contains:
  - the remainder, divisor and quotient registers;
  - the subtractor and incrementer;
  - the `ge` (remainder >= divisor) and `bz` (divisor == 0) status flags.
- Unknown state encodings decode to IDLE on the next edge.

## Test plan
- 100 / 7, WIDTH=16: `quotient`=14, `remainder`=2, `div_zero`=0; `done` rises in cycle 18 (4+14).
- 5 / 9: `quotient`=0, `remainder`=5; `done` rises in cycle 4. Also 0 / 3: `quotient`=0, `remainder`=0, `done` rises in cycle 4.
- 42 / 0: `div_zero`=1, `quotient`=0, `remainder`=42; `done` rises in cycle 4.
- 9 / 9 gives `quotient`=1, `remainder`=0. With WIDTH=8, 255 / 1 gives `quotient`=255, `remainder`=0, and `done` rises in cycle 259.
- Assert `rst` during ITER of 1000 / 3: next cycle is IDLE with all outputs 0. A subsequent 20 / 6 then gives `quotient`=3, `remainder`=2.
- Handshake:
  - Hold `start`=1 after `done`: the block stays in DONE and outputs are stable.
  - Pulse `start` during ITER: it has no effect.
  - Drop `start`: the block returns to IDLE and the results are retained.
